axilite_req_arbiter: RTL
========================

Name: axilite_req_arbiter

Overview:
- Shares one easy_axilite_master user interface (addr/wdata/opcode in; rdata/rvalid/wdone/rd_err/wr_err/busy out) between NUM_REQ command requesters.
- Typical requesters are xvc_controller_core and a management/debug agent.
- Arbitration is round-robin, with one outstanding transaction at a time.
- Each completion is routed back to the requester that issued it.
- Sits between the requesters and easy_axilite_master inside the XVC subsystem.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_LEN, 16, AXI-Lite address width.
- DATA_LEN, 32, AXI-Lite data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester command valid; requester holds it and its payload until req_ready.
- req_opcode  in  2*NUM_REQ  per-requester opcode: 2'b01 read, 2'b10 write, 2'b00/2'b11 illegal.
- req_addr  in  ADDR_LEN*NUM_REQ  per-requester address.
- req_wdata  in  DATA_LEN*NUM_REQ  per-requester write data.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the winner.
- resp_valid  out  NUM_REQ  one-cycle completion pulse to the owner.
- resp_rdata  out  DATA_LEN  read data, shared; qualified by resp_valid.
- resp_err  out  1  error flag, shared; qualified by resp_valid.
- m_addr  out  ADDR_LEN  to master addr.
- m_wdata  out  DATA_LEN  to master wdata.
- m_opcode  out  2  to master opcode; 2'b00 is NOP.
- m_rdata  in  DATA_LEN  from master.
- m_rvalid  in  1  from master, read complete.
- m_wdone  in  1  from master, write complete.
- m_rd_err  in  1  from master, read error, coincident with m_rvalid.
- m_wr_err  in  1  from master, write error, coincident with m_wdone.
- m_busy  in  1  from master.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, rr pointer 0, owner 0, all outputs 0 (m_opcode=NOP), captured payload 0.
- All outputs are registered.
- State IDLE:
  - If any req_valid and m_busy==0, pick the winner round-robin starting at (last_winner+1) mod NUM_REQ, wrapping.
  - Capture the winner's opcode/addr/wdata, owner, and last_winner.
  - Legal opcode -> ISSUE. Illegal opcode -> REJECT.
  - If m_busy==1, stay in IDLE; no grant.
- State ISSUE (1 cycle):
  - m_opcode = captured opcode, m_addr/m_wdata = captured values.
  - req_ready[owner] = 1.
  - Next state WAIT.
- State WAIT:
  - m_opcode = NOP; m_addr/m_wdata hold their values.
  - On m_rvalid (read) or m_wdone (write): resp_valid[owner] = 1 the next cycle.
    - resp_rdata = m_rdata for a read; 0 for a write.
    - resp_err = m_rd_err or m_wr_err.
  - Next state IDLE.
  - No timeout: wait indefinitely.
- State REJECT (1 cycle):
  - req_ready[owner] = 1 and resp_valid[owner] = 1 in the same cycle, resp_err = 1, resp_rdata = 0.
  - No master transaction.
  - Next state IDLE.
- Latency: IDLE grant at cycle T -> m_opcode and req_ready at T+1 -> completion seen at T+k -> resp_valid at T+k+1.
- After resp_valid, a new grant is possible the same cycle, then ISSUE the next.
- Boundary conditions:
  - m_rvalid/m_wdone outside WAIT are ignored (no resp_valid).
  - A completion that does not match the opcode type is ignored (a wdone during a read stays in WAIT).
  - Simultaneous m_rvalid and m_wdone: take the one matching the opcode.
  - req_valid dropped before grant: no effect; arbitration is re-evaluated every IDLE cycle.
  - A single requester continuously valid gets back-to-back service with no starvation of the others.
  - resp_valid and req_ready are never asserted to a non-owner.
  - Reset mid-ISSUE/WAIT: immediate return to IDLE, outputs 0, in-flight response dropped.

Decomposition:
- Package axilite_arb_pkg:
  - Opcode constants OP_NOP=2'b00, OP_RD=2'b01, OP_WR=2'b10.
  - State encoding IDLE/ISSUE/WAIT/REJECT.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, last_winner.
  - Outputs: grant index, any_req.
  - Implemented as masked priority encoder plus unmasked fallback.

Test Plan:
- Single read: req_valid[0], opcode 01, addr 0x0010; master returns rvalid after 3 cycles with rdata 0xCAFE0001 -> req_ready[0] at T+1; m_opcode=01, m_addr=0x0010 for exactly 1 cycle; resp_valid[0] with rdata 0xCAFE0001, err 0.
- Contention: req_valid=2'b11 held, 4 transactions -> grant order 1,0,1,0 from reset (last_winner=0); each req_ready routed correctly; no overlap of m_opcode.
- Write error: req 1, opcode 10, addr 0x0004, wdata 0x0000_00FF; wdone with wr_err=1 -> resp_valid[1], resp_err=1, resp_rdata=0.
- Illegal opcode 11 on req 0 -> req_ready[0] and resp_valid[0] same cycle, resp_err=1, m_opcode stays 00 throughout.
- m_busy held high 5 cycles with req pending -> no grant until the cycle after busy falls; completion pulses injected in IDLE -> no resp_valid.
- Assert rst low during WAIT -> all outputs 0 asynchronously; after release, a new read on req 1 completes normally.

Source files
------------

// File: rtl/axilite_req_arbiter_pkg.sv
// Shared opcode constants, state encoding and helpers for the AXI-Lite request arbiter.
package axilite_arb_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_NOP = 2'b00;
  localparam opcode_t OP_RD  = 2'b01;
  localparam opcode_t OP_WR  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REJECT = 2'd3
  } arb_state_t;

  function automatic logic op_legal(input opcode_t op);
    return (op == OP_RD) || (op == OP_WR);
  endfunction

endpackage

// File: rtl/axilite_req_arbiter_if.sv
// Command/completion bus between the arbiter and easy_axilite_master.
interface axilite_req_arbiter_if
  import axilite_arb_pkg::*;
#(
  parameter int ADDR_LEN = 16,
  parameter int DATA_LEN = 32
);

  logic [ADDR_LEN-1:0] m_addr;
  logic [DATA_LEN-1:0] m_wdata;
  opcode_t             m_opcode;
  logic [DATA_LEN-1:0] m_rdata;
  logic                m_rvalid;
  logic                m_wdone;
  logic                m_rd_err;
  logic                m_wr_err;
  logic                m_busy;

  // The arbiter issues commands; the AXI-Lite master answers them.
  modport master (
    output m_addr, m_wdata, m_opcode,
    input  m_rdata, m_rvalid, m_wdone, m_rd_err, m_wr_err, m_busy
  );

  modport slave (
    input  m_addr, m_wdata, m_opcode,
    output m_rdata, m_rvalid, m_wdone, m_rd_err, m_wr_err, m_busy
  );

endinterface

// File: rtl/axilite_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_winner, else lowest requester.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_winner,
  output logic [IW-1:0]      grant,
  output logic               any_req
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IW'(i) > last_winner)) begin
        grant = IW'(i);
        found = 1'b1;
      end
    end
    // Nobody above the pointer: wrap around to the lowest active index.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        grant = IW'(i);
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axilite_req_arbiter.sv
// Round-robin sharing of one easy_axilite_master among NUM_REQ requesters, one transaction in flight.
module axilite_req_arbiter
  import axilite_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_LEN = 16,
  parameter int DATA_LEN = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [2*NUM_REQ-1:0]         req_opcode,
  input  logic [ADDR_LEN*NUM_REQ-1:0]  req_addr,
  input  logic [DATA_LEN*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [DATA_LEN-1:0]          resp_rdata,
  output logic                         resp_err,
  axilite_req_arbiter_if.master        mbus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state, state_d;
  logic [IW-1:0]       owner, owner_d;
  logic [IW-1:0]       last_winner, last_d;
  opcode_t             op_q, op_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  opcode_t             m_opcode_d;
  logic [NUM_REQ-1:0]  req_ready_d, resp_valid_d;
  logic [DATA_LEN-1:0] resp_rdata_d;
  logic                resp_err_d;

  logic [IW-1:0]       grant;
  logic                any_req;
  opcode_t             win_op;
  logic [ADDR_LEN-1:0] win_addr;
  logic [DATA_LEN-1:0] win_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req         (req_valid),
    .last_winner (last_winner),
    .grant       (grant),
    .any_req     (any_req)
  );

  assign win_op    = req_opcode[2*grant +: 2];
  assign win_addr  = req_addr[ADDR_LEN*grant +: ADDR_LEN];
  assign win_wdata = req_wdata[DATA_LEN*grant +: DATA_LEN];

  assign mbus.m_addr  = addr_q;
  assign mbus.m_wdata = wdata_q;

  // Next-state logic; the pulse outputs are computed a cycle early so they leave registers.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_d       = last_winner;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m_opcode_d   = OP_NOP;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req && !mbus.m_busy) begin
          owner_d            = grant;
          last_d             = grant;
          op_d               = win_op;
          addr_d             = win_addr;
          wdata_d            = win_wdata;
          req_ready_d[grant] = 1'b1;
          if (op_legal(win_op)) begin
            state_d    = ST_ISSUE;
            m_opcode_d = win_op;
          end else begin
            state_d             = ST_REJECT;
            resp_valid_d[grant] = 1'b1;
            resp_err_d          = 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Only the completion type matching the issued opcode ends the wait.
        if (op_q == OP_RD && mbus.m_rvalid) begin
          resp_valid_d[owner] = 1'b1;
          resp_rdata_d        = mbus.m_rdata;
          resp_err_d          = mbus.m_rd_err;
          state_d             = ST_IDLE;
        end else if (op_q == OP_WR && mbus.m_wdone) begin
          resp_valid_d[owner] = 1'b1;
          resp_err_d          = mbus.m_wr_err;
          state_d             = ST_IDLE;
        end
      end
      ST_REJECT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      owner         <= '0;
      last_winner   <= '0;
      op_q          <= OP_NOP;
      addr_q        <= '0;
      wdata_q       <= '0;
      mbus.m_opcode <= OP_NOP;
      req_ready     <= '0;
      resp_valid    <= '0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else begin
      state         <= state_d;
      owner         <= owner_d;
      last_winner   <= last_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mbus.m_opcode <= m_opcode_d;
      req_ready     <= req_ready_d;
      resp_valid    <= resp_valid_d;
      resp_rdata    <= resp_rdata_d;
      resp_err      <= resp_err_d;
    end
  end

endmodule
